// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: WIDTH+1 add/sub+shift steps, done pulses WIDTH+2 cycles after start.
// start is ignored while busy; define SIGNED_SEL_EN to add a signed_mode port (default: always signed).
module booth_seq_mult #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
`ifdef SIGNED_SEL_EN
   input  logic                 signed_mode,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH:0]   m_reg, a_reg, q_reg;
   logic             q_1;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   a_op, a_sh, q_sh;
   logic             ext_a, ext_b;

   // One extra operand bit lets the same signed datapath serve unsigned inputs.
`ifdef SIGNED_SEL_EN
   assign ext_a = signed_mode & a[WIDTH-1];
   assign ext_b = signed_mode & b[WIDTH-1];
`else
   assign ext_a = a[WIDTH-1];
   assign ext_b = b[WIDTH-1];
`endif

   always_comb begin
      a_op = a_reg;
      case ({q_reg[0], q_1})
         2'b01:   a_op = a_reg + m_reg;
         2'b10:   a_op = a_reg - m_reg;
         default: a_op = a_reg;
      endcase
      a_sh = {a_op[WIDTH], a_op[WIDTH:1]};
      q_sh = {a_op[0], q_reg[WIDTH:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = CALC;
         CALC: begin
            busy = 1'b1;
            if (cnt == CW'(1)) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_reg   <= '0;
         a_reg   <= '0;
         q_reg   <= '0;
         q_1     <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               m_reg <= {ext_a, a};
               q_reg <= {ext_b, b};
               a_reg <= '0;
               q_1   <= 1'b0;
               cnt   <= CW'(WIDTH + 1);
            end
            CALC: begin
               a_reg <= a_sh;
               q_reg <= q_sh;
               q_1   <= q_reg[0];
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) product <= {a_sh[WIDTH-2:0], q_sh};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult at WIDTH=4 and WIDTH=8 with hand-computed products.
// Monitors check product, fixed latency, busy during operations and product stability between results.
module tb_booth_seq_mult;

   typedef struct {
      logic [15:0] p;
      int          k;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, start8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  product4;
   logic [15:0] product8;
`ifdef SIGNED_SEL_EN
   logic        sm4;
   logic        sm8 = 1'b1;
`endif

   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;
   exp_t q4[$];
   exp_t q8[$];
   exp_t m4e, m8e;
   logic [7:0]  held4 = '0;
   logic [15:0] held8 = '0;

   booth_seq_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
`ifdef SIGNED_SEL_EN
      .signed_mode(sm4),
`endif
      .busy(busy4), .done(done4), .product(product4)
   );

   booth_seq_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef SIGNED_SEL_EN
      .signed_mode(sm8),
`endif
      .busy(busy8), .done(done8), .product(product8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s at cycle %0d: wait bound expired", name, cyc);
   endtask

   task automatic issue4(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp);
      exp_t e;
      int   t = 0;
      @(negedge clk);
      while (busy4 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (busy4) bound_fail("issue4_idle");
      a4 = x; b4 = y; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      e.p = {8'h00, exp};
      e.k = cyc;
      q4.push_back(e);
   endtask

   task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
      exp_t e;
      int   t = 0;
      @(negedge clk);
      while (busy8 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (busy8) bound_fail("issue8_idle");
      a8 = x; b8 = y; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      e.p = exp;
      e.k = cyc;
      q8.push_back(e);
   endtask

   // Accepted at edge k, the result is visible in the cycle after edge k+WIDTH+1.
   always @(negedge clk) if (mon_en) begin
      if (done4) begin
         if (q4.size() == 0) bound_fail("done4_unexpected");
         else begin
            m4e = q4.pop_front();
            chk("product4", 32'(product4), 32'(m4e.p[7:0]));
            chk("latency4", 32'(cyc), 32'(m4e.k + 5));
            chk("busy4_at_done", 32'(busy4), 32'd1);
            held4 = m4e.p[7:0];
         end
      end else begin
         chk("hold4", 32'(product4), 32'(held4));
         if (q4.size() != 0 && cyc >= q4[0].k) begin
            chk("busy4_calc", 32'(busy4), 32'd1);
            if (cyc > q4[0].k + 5) begin
               bound_fail("done4_missing");
               m4e = q4.pop_front();
            end
         end
      end
   end

   always @(negedge clk) if (mon_en) begin
      if (done8) begin
         if (q8.size() == 0) bound_fail("done8_unexpected");
         else begin
            m8e = q8.pop_front();
            chk("product8", 32'(product8), 32'(m8e.p));
            chk("latency8", 32'(cyc), 32'(m8e.k + 9));
            chk("busy8_at_done", 32'(busy8), 32'd1);
            held8 = m8e.p;
         end
      end else begin
         chk("hold8", 32'(product8), 32'(held8));
         if (q8.size() != 0 && cyc >= q8[0].k) begin
            chk("busy8_calc", 32'(busy8), 32'd1);
            if (cyc > q8[0].k + 9) begin
               bound_fail("done8_missing");
               m8e = q8.pop_front();
            end
         end
      end
   end

   initial begin
      int t;
      rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
`ifdef SIGNED_SEL_EN
      sm4 = 1'b1;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy4", 32'(busy4), 32'd0);
      chk("reset_done4", 32'(done4), 32'd0);
      chk("reset_product4", 32'(product4), 32'd0);
      chk("reset_product8", 32'(product8), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Signed WIDTH=4, issued back-to-back.
      issue4(4'h3, 4'h5, 8'h0F);
      issue4(4'hD, 4'h5, 8'hF1);
      issue4(4'h7, 4'hF, 8'hF9);
      issue4(4'h8, 4'h8, 8'h40);
      issue4(4'h0, 4'h5, 8'h00);
      issue4(4'hF, 4'hF, 8'h01);
      issue4(4'h7, 4'h7, 8'h31);
      issue4(4'h8, 4'h7, 8'hC8);
`ifdef SIGNED_SEL_EN
      sm4 = 1'b0;
      issue4(4'hF, 4'hF, 8'hE1);
      issue4(4'h8, 4'h8, 8'h40);
      issue4(4'hF, 4'h1, 8'h0F);
      sm4 = 1'b1;
      issue4(4'hF, 4'hF, 8'h01);
`endif

      // A second start mid-calculation with new operands must be ignored.
      issue4(4'h2, 4'h3, 8'h06);
      @(negedge clk);
      @(negedge clk);
      a4 = 4'h9; b4 = 4'h2; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;

      // Reset during the second calculation cycle aborts the operation.
      issue4(4'h6, 4'h3, 8'h12);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      q4.delete();
      held4 = '0;
      held8 = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy4", 32'(busy4), 32'd0);
      chk("abort_done4", 32'(done4), 32'd0);
      chk("abort_product4", 32'(product4), 32'd0);
      issue4(4'h5, 4'hB, 8'hE7);

      // Signed WIDTH=8.
      issue8(8'h7F, 8'h7F, 16'h3F01);
      issue8(8'h80, 8'h80, 16'h4000);
      issue8(8'h80, 8'h7F, 16'hC080);
      issue8(8'hFF, 8'hFF, 16'h0001);
      issue8(8'h64, 8'hFD, 16'hFED4);
      issue8(8'h00, 8'hB3, 16'h0000);
      issue8(8'h55, 8'hAA, 16'hE372);
      issue8(8'h19, 8'h14, 16'h01F4);

      t = 0;
      while ((q4.size() != 0 || q8.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (q4.size() != 0 || q8.size() != 0) bound_fail("drain");
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
